// File: rtl/conv_tile_sched.sv
// conv_tile_sched
//   Sequences one 2D tile pass over an on-chip buffer. A row/column nest
//   generates read addresses and strobes, a PIPE_LAT-deep valid shift
//   register follows each read through the compute pipeline, and each
//   read that emerges becomes a write to the next sequential result
//   address. process_stall freezes the read side, the pipeline tracker
//   and the write side together.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start           begin a pass (sampled only while idle)
//   row_num/col_num tile dimensions, latched on accepted start
//   base_addr       read address of element (0,0), latched on accepted start
//   row_stride      read address step between rows, latched on accepted start
//   process_stall   freezes all progress while high
//   busy            high from the cycle after start acceptance until done
//   done            one-cycle pulse at the end of the pass
//   rd_ena/rd_addr  registered read strobe and address
//   wr_ena/wr_addr  registered write strobe and result-buffer address
module conv_tile_sched #(
    parameter int AW       = 10,
    parameter int DIM_W    = 8,
    parameter int PIPE_LAT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIM_W-1:0] row_num,
    input  logic [DIM_W-1:0] col_num,
    input  logic [AW-1:0]    base_addr,
    input  logic [AW-1:0]    row_stride,
    input  logic             process_stall,
    output logic             busy,
    output logic             done,
    output logic             rd_ena,
    output logic [AW-1:0]    rd_addr,
    output logic             wr_ena,
    output logic [AW-1:0]    wr_addr
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]          state;
    logic [DIM_W-1:0]    row_num_q;
    logic [DIM_W-1:0]    col_num_q;
    logic [AW-1:0]       row_stride_q;
    logic [DIM_W-1:0]    row;
    logic [DIM_W-1:0]    col;
    logic [AW-1:0]       row_base;
    logic [AW-1:0]       wr_cnt;
    logic [PIPE_LAT-1:0] vld_pipe;

    logic issue;
    logic vld_tail;
    logic last_col;
    logic last_row;

    // A read goes out on every non-stalled RUN cycle.
    assign issue    = (state == S_RUN) && !process_stall;
    assign vld_tail = vld_pipe[PIPE_LAT-1];
    // Dimensions are non-zero whenever RUN is reached, so the -1 cannot underflow.
    assign last_col = (col == col_num_q - DIM_W'(1));
    assign last_row = (row == row_num_q - DIM_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            rd_ena       <= 1'b0;
            rd_addr      <= '0;
            wr_ena       <= 1'b0;
            wr_addr      <= '0;
            row_num_q    <= '0;
            col_num_q    <= '0;
            row_stride_q <= '0;
            row          <= '0;
            col          <= '0;
            row_base     <= '0;
            wr_cnt       <= '0;
            vld_pipe     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    rd_ena <= 1'b0;
                    wr_ena <= 1'b0;
                    if (start) begin
                        row_num_q    <= row_num;
                        col_num_q    <= col_num;
                        row_stride_q <= row_stride;
                        row_base     <= base_addr;
                        row          <= '0;
                        col          <= '0;
                        wr_cnt       <= '0;
                        wr_addr      <= '0;
                        vld_pipe     <= '0;
                        busy         <= 1'b1;
                        if (row_num == '0 || col_num == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN, S_DRAIN: begin
                    if (process_stall) begin
                        rd_ena <= 1'b0;
                        wr_ena <= 1'b0;
                    end else begin
                        // read issue -> valid tracker stage boundary
                        rd_ena   <= issue;
                        vld_pipe <= (vld_pipe << 1) | PIPE_LAT'(issue);
                        // tracker tail -> write stage boundary
                        wr_ena <= vld_tail;
                        if (vld_tail) begin
                            wr_addr <= wr_cnt;
                            wr_cnt  <= wr_cnt + AW'(1);
                        end
                        if (state == S_RUN) begin
                            rd_addr <= row_base + AW'(col);
                            if (last_col) begin
                                col      <= '0;
                                row      <= row + DIM_W'(1);
                                row_base <= row_base + row_stride_q;
                                if (last_row) state <= S_DRAIN;
                            end else begin
                                col <= col + DIM_W'(1);
                            end
                        end else if (vld_pipe == '0) begin
                            // Tracker empty means the final write went out last cycle.
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    rd_ena <= 1'b0;
                    wr_ena <= 1'b0;
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_tile_sched.sv
module tb_conv_tile_sched;

    localparam int AW       = 10;
    localparam int DIM_W    = 8;
    localparam int PIPE_LAT = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [DIM_W-1:0] row_num;
    logic [DIM_W-1:0] col_num;
    logic [AW-1:0]    base_addr;
    logic [AW-1:0]    row_stride;
    logic             process_stall;
    logic             busy;
    logic             done;
    logic             rd_ena;
    logic [AW-1:0]    rd_addr;
    logic             wr_ena;
    logic [AW-1:0]    wr_addr;

    int total = 0;
    int bad   = 0;

    conv_tile_sched #(.AW(AW), .DIM_W(DIM_W), .PIPE_LAT(PIPE_LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .row_num(row_num), .col_num(col_num),
        .base_addr(base_addr), .row_stride(row_stride), .process_stall(process_stall),
        .busy(busy), .done(done), .rd_ena(rd_ena), .rd_addr(rd_addr),
        .wr_ena(wr_ena), .wr_addr(wr_addr)
    );

    always #5 clk = ~clk;

    // Each vector: tile config, stall mask (bit c = stall during cycle c after
    // acceptance), expected read count, last read address, done cycle index.
    typedef struct {
        string name;
        int    rows;
        int    cols;
        int    base;
        int    stride;
        int    stall;
        int    exp_n;
        int    exp_last;
        int    exp_done;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic run_pass(input vec_t v);
        logic [AW-1:0] exp_q[$];
        logic [AW-1:0] last_rd;
        int nrd, nwr, ndone, done_at, tmp;
        bit finished;
        for (int r = 0; r < v.rows; r++)
            for (int c = 0; c < v.cols; c++) begin
                tmp = v.base + r * v.stride + c;
                exp_q.push_back(AW'(tmp));
            end
        nrd = 0; nwr = 0; ndone = 0; done_at = -1; finished = 0; last_rd = '0;
        row_num    = DIM_W'(v.rows);
        col_num    = DIM_W'(v.cols);
        base_addr  = AW'(v.base);
        row_stride = AW'(v.stride);
        start      = 1'b1;
        tick();
        start      = 1'b0;
        // Scramble config to show it was latched.
        row_num    = 8'hA5;
        col_num    = 8'h5A;
        base_addr  = 10'h155;
        row_stride = 10'h2AA;
        for (int c = 0; c < 200 && !finished; c++) begin
            if (rd_ena) begin
                if (nrd < exp_q.size()) chk({v.name, " rd_addr"}, 32'(rd_addr), 32'(exp_q[nrd]));
                last_rd = rd_addr;
                nrd++;
            end
            if (wr_ena) begin
                chk({v.name, " wr_addr"}, 32'(wr_addr), 32'(nwr));
                nwr++;
            end
            if (done_at >= 0 && c == done_at + 1) begin
                chk({v.name, " busy after done"}, 32'(busy), 32'd0);
                finished = 1;
            end
            if (done) begin
                ndone++;
                if (done_at < 0) begin
                    done_at = c;
                    chk({v.name, " busy in done"}, 32'(busy), 32'd1);
                end
            end
            process_stall = (c < 32) ? v.stall[c] : 1'b0;
            if (!finished) tick();
        end
        process_stall = 1'b0;
        chk({v.name, " finished"}, 32'(finished), 32'd1);
        chk({v.name, " reads"}, 32'(nrd), 32'(v.exp_n));
        chk({v.name, " writes"}, 32'(nwr), 32'(v.exp_n));
        chk({v.name, " done cycle"}, 32'(done_at), 32'(v.exp_done));
        chk({v.name, " done pulses"}, 32'(ndone), 32'd1);
        if (v.exp_n > 0) chk({v.name, " last rd"}, 32'(last_rd), 32'(v.exp_last));
        tick();
    endtask

    initial begin
        logic [AW-1:0] rd_seen[$];
        int done1, done2, busy7, busy8, ndone, tmp_wr;

        vecs[0] = '{"basic2x3",  2, 3, 'h010, 'h020, 0,       6, 'h032, 10};
        vecs[1] = '{"stall1x4",  1, 4, 'h100, 'h000, 'b1100,  4, 'h103, 10};
        vecs[2] = '{"zero_rows", 0, 5, 'h000, 'h000, 0,       0, 0,      0};
        vecs[3] = '{"wrap1x4",   1, 4, 'h3FE, 'h000, 0,       4, 'h001,  8};
        vecs[4] = '{"wrap3x2",   3, 2, 'h3F0, 'h008, 0,       6, 'h001, 10};
        vecs[5] = '{"zero_cols", 5, 0, 'h000, 'h000, 0,       0, 0,      0};
        vecs[6] = '{"single",    1, 1, 'h055, 'h000, 0,       1, 'h055,  5};

        rst = 1'b1; start = 1'b0; process_stall = 1'b0;
        row_num = '0; col_num = '0; base_addr = '0; row_stride = '0;
        tick(); tick();
        rst = 1'b0;
        chk("reset busy",    32'(busy),    32'd0);
        chk("reset done",    32'(done),    32'd0);
        chk("reset rd_ena",  32'(rd_ena),  32'd0);
        chk("reset wr_ena",  32'(wr_ena),  32'd0);
        chk("reset rd_addr", 32'(rd_addr), 32'd0);
        chk("reset wr_addr", 32'(wr_addr), 32'd0);
        tick();

        for (int i = 0; i < 7; i++) run_pass(vecs[i]);

        // start held high: two 1x2 passes back-to-back, config switched mid-run.
        row_num = 8'd1; col_num = 8'd2; base_addr = 10'h040; row_stride = 10'h000;
        start = 1'b1;
        tick();
        base_addr = 10'h080;
        done1 = -1; done2 = -1; busy7 = -1; busy8 = -1; ndone = 0;
        for (int c = 0; c < 40 && done2 < 0; c++) begin
            if (rd_ena) rd_seen.push_back(rd_addr);
            if (c == 7) busy7 = busy;
            if (c == 8) busy8 = busy;
            if (done) begin
                ndone++;
                if (done1 < 0) done1 = c;
                else begin
                    done2 = c;
                    start = 1'b0;
                end
            end
            tick();
        end
        start = 1'b0;
        chk("held reads", 32'(rd_seen.size()), 32'd4);
        if (rd_seen.size() == 4) begin
            chk("held rd0", 32'(rd_seen[0]), 32'h040);
            chk("held rd1", 32'(rd_seen[1]), 32'h041);
            chk("held rd2", 32'(rd_seen[2]), 32'h080);
            chk("held rd3", 32'(rd_seen[3]), 32'h081);
        end
        chk("held done1", 32'(done1), 32'd6);
        chk("held done2", 32'(done2), 32'd14);
        chk("held idle gap", 32'(busy7), 32'd0);
        chk("held restart", 32'(busy8), 32'd1);
        for (int c = 0; c < 10; c++) begin
            if (busy) begin
                chk("held no third pass", 32'(busy), 32'd0);
                break;
            end
            tick();
        end

        // Reset mid-pass of a 4x4 tile.
        row_num = 8'd4; col_num = 8'd4; base_addr = 10'h200; row_stride = 10'h010;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick(); tick(); tick();
        chk("midpass running", 32'(rd_ena), 32'd1);
        tmp_wr = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst busy",    32'(busy),    32'd0);
        chk("midrst rd_ena",  32'(rd_ena),  32'd0);
        chk("midrst wr_ena",  32'(wr_ena),  32'd0);
        chk("midrst rd_addr", 32'(rd_addr), 32'd0);
        chk("midrst wr_addr", 32'(wr_addr), 32'd0);
        for (int c = 0; c < 8; c++) begin
            if (done || rd_ena || wr_ena || busy) tmp_wr++;
            tick();
        end
        chk("midrst quiet", 32'(tmp_wr), 32'd0);
        run_pass('{"after_rst4x4", 4, 4, 'h200, 'h010, 0, 16, 'h233, 20});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_tile_sched.md
Name: conv_tile_sched

Overview:
- Sequences one 2D tile pass over an on-chip buffer for the CNN datapath.
- Walks a row/column nest to produce read addresses and read enables, and tracks the compute pipeline latency.
- Produces sequential write addresses for the result buffer, with start/done handshake to the top-level controller.
- Honours the shared process_stall so the read side, pipeline tracking and write side freeze together.

Parameters:
- AW, 10, buffer address width.
- DIM_W, 8, width of tile row/column counts.
- PIPE_LAT, 3, cycles from rd_ena to the matching wr_ena; range 1..15.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a tile pass; sampled only in IDLE.
- row_num  input  DIM_W  tile rows; latched on accepted start.
- col_num  input  DIM_W  tile columns; latched on accepted start.
- base_addr  input  AW  read address of element (0,0); latched on accepted start.
- row_stride  input  AW  read address step between rows; latched on accepted start.
- process_stall  input  1  freezes all progress while high.
- busy  output  1  high from the cycle after start acceptance until done.
- done  output  1  one-cycle pulse at pass end.
- rd_ena  output  1  read strobe, registered.
- rd_addr  output  AW  read address, valid when rd_ena=1, registered.
- wr_ena  output  1  write strobe, registered.
- wr_addr  output  AW  result-buffer write address, valid when wr_ena=1, registered.

Behaviour:
- Reset: state=IDLE; busy, done, rd_ena, wr_ena = 0; rd_addr, wr_addr, row/col counters and pipeline valid shift register = 0.
  - Reset mid-pass abandons the pass immediately; no done pulse.
- IDLE:
  - start=1 latches the config.
  - If row_num==0 or col_num==0, go to DONE with no rd_ena or wr_ena.
  - Otherwise go to RUN with row=col=0 and row_base=base_addr.
  - busy=1 from the next cycle.
- RUN, each cycle with process_stall=0:
  - rd_ena<=1, rd_addr<=row_base+col (mod 2^AW).
  - If col<col_num-1: col++.
  - Else: col<=0, row++, row_base<=row_base+row_stride (mod 2^AW).
  - Issuing the last element (row==row_num-1, col==col_num-1) moves to DRAIN.
  - Issued count is exactly row_num*col_num.
- Stall, process_stall=1 in any state except IDLE/DONE:
  - rd_ena<=0, wr_ena<=0.
  - Counters, row_base, wr_addr and the pipeline shift register all hold.
- Pipeline tracking:
  - A PIPE_LAT-deep valid shift register advances only on non-stalled cycles; its input is the rd_ena being issued.
  - wr_ena<=tail bit on non-stalled cycles.
  - Each wr_ena=1 uses the current wr_addr, which then increments; wr_addr restarts at 0 on every accepted start.
  - Result: wr_ena rises exactly PIPE_LAT non-stalled cycles after its rd_ena.
- DRAIN:
  - rd_ena=0; the shift register keeps advancing.
  - When it is all-zero and the last wr_ena has been issued, go to DONE.
- DONE:
  - done=1 for exactly one cycle, busy<=0, return to IDLE.
  - A start in the DONE cycle is ignored; a start on the following cycle is accepted.
- start outside IDLE is ignored; config inputs may change freely after acceptance.
- Address wrap at 2^AW is silent; no error flag.

Test Plan:
- Basic 2x3 tile:
  - Stimulus: base_addr=0x010, row_stride=0x020, PIPE_LAT=3, no stall.
  - Response: rd_addr sequence 0x010,0x011,0x012,0x030,0x031,0x032 on 6 consecutive cycles.
  - Response: wr_ena on 6 consecutive cycles starting 3 cycles after the first rd_ena, wr_addr 0..5; done pulses one cycle after the last wr_ena, busy then falls.
- Stall mid-run, 1x4 tile:
  - Stimulus: process_stall high for 2 cycles after the second read.
  - Response: rd_ena low for 2 cycles, rd_addr resumes at base+2.
  - Response: wr_ena gaps mirror the stall; total 4 writes; done delayed by exactly 2 cycles.
- Zero dimension:
  - Stimulus: row_num=0, col_num=5, start.
  - Response: no rd_ena or wr_ena; done pulses 1 cycle after start; busy stays 0 except in the DONE cycle.
- Wrap-around, AW=10:
  - Stimulus: base_addr=0x3FE, 1x4 tile.
  - Response: rd_addr 0x3FE,0x3FF,0x000,0x001.
- Start handling:
  - Stimulus: start held high continuously.
  - Response: passes run back-to-back with one IDLE cycle between; start pulses during RUN have no effect on addresses.
- Reset mid-pass:
  - Stimulus: rst asserted during RUN of a 4x4 tile.
  - Response: next cycle all outputs 0, state IDLE, no done pulse; a new start then produces a full 16-read pass with wr_addr starting at 0.
